serial_adder_ctrl: RTL and testbench

- Bit-serial adder datapath and controller. Accepts two WIDTH-bit operands plus carry-in through a valid/ready handshake, then streams them LSB-first through one internal full_adder instance, one bit per clock.
- Returns the WIDTH-bit sum, carry-out and signed-overflow flag through a valid/ready output handshake.
- Sits directly upstream of the full_adder cell, feeding its a/b/cin inputs and consuming its s/c outputs. It is the area-minimal alternative to the ripple-carry array.

---
 rtl/serial_adder_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: operands are streamed LSB-first through a single full_adder
// cell, one bit per clock, behind valid/ready handshakes on both sides.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);
    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one operand bit pair added per clock, WIDTH clocks total
// DONE  | result held on sum/cout/ovf, out_valid high until out_ready
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-2:0]  r_sum_sh;
    logic              r_carry;
    logic              r_msb_cin;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;

    logic              w_fa_s;
    logic              w_fa_c;
    logic              w_accept;
    logic              w_run;
    logic              w_last;
    logic [WIDTH-1:0]  w_sum_next;

    full_adder u_fa (
        .a   (r_a_sh[0]),
        .b   (r_b_sh[0]),
        .cin (r_carry),
        .s   (w_fa_s),
        .c   (w_fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake outputs depend on state only, never on in_valid/out_ready.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (r_cnt == CNT_LAST) w_next_state = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_run      = (r_state == S_RUN);
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_sum_next = {w_fa_s, r_sum_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_sum_sh  <= '0;
            r_carry   <= 1'b0;
            r_msb_cin <= 1'b0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_sum_sh <= w_sum_next[WIDTH-1:1];
            r_carry  <= w_fa_c;
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            // Counter stops at WIDTH-1 so it never wraps for power-of-two widths.
            if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_PEN) r_msb_cin <= w_fa_c;
            if (w_last) begin
                r_sum  <= w_sum_next;
                r_cout <= w_fa_c;
                r_ovf  <= r_msb_cin ^ w_fa_c;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 and WIDTH=2 instances checked every cycle
// against an arithmetic model, plus directed literal expectations.

module tb_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv   [2];
    logic        orr  [2];
    logic [63:0] ina  [2];
    logic [63:0] inb  [2];
    logic        icin [2];
    logic        iready [2];
    logic        ovalid [2];
    logic [63:0] osum   [2];
    logic        ocout  [2];
    logic        oovf   [2];
    logic [7:0]  s8;
    logic [1:0]  s2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(iready[0]),
        .a(ina[0][7:0]), .b(inb[0][7:0]), .cin(icin[0]), .out_valid(ovalid[0]),
        .out_ready(orr[0]), .sum(s8), .cout(ocout[0]), .ovf(oovf[0])
    );

    serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(iready[1]),
        .a(ina[1][1:0]), .b(inb[1][1:0]), .cin(icin[1]), .out_valid(ovalid[1]),
        .out_ready(orr[1]), .sum(s2), .cout(ocout[1]), .ovf(oovf[1])
    );

    assign osum[0] = {56'd0, s8};
    assign osum[1] = {62'd0, s2};

    function automatic int wid(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    // Returns {sum[63:0], cout, ovf} from plain integer arithmetic.
    function automatic logic [65:0] calc(input int w, input logic [63:0] x,
                                         input logic [63:0] y, input logic c);
        longint unsigned mask, ux, uy, full;
        longint sx, sy, ss, lim;
        logic o;
        mask = (64'd1 << w) - 1;
        ux   = x & mask;
        uy   = y & mask;
        full = ux + uy + longint'(c);
        sx   = ux[w-1] ? longint'(ux) - (longint'(1) << w) : longint'(ux);
        sy   = uy[w-1] ? longint'(uy) - (longint'(1) << w) : longint'(uy);
        ss   = sx + sy + longint'(c);
        lim  = longint'(1) << (w - 1);
        o    = (ss > lim - 1) || (ss < -lim);
        return {64'(full & mask), 1'(full >> w), o};
    endfunction

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: ready -> busy for WIDTH edges -> valid until out_ready.
    logic        m_ready [2];
    logic        m_valid [2];
    int          m_left  [2];
    logic [65:0] m_pend  [2];
    logic [65:0] m_res   [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_ready[i] <= 1'b1;
                m_valid[i] <= 1'b0;
                m_left[i]  <= 0;
                m_pend[i]  <= '0;
                m_res[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_ready[i]) begin
                    if (iv[i]) begin
                        m_ready[i] <= 1'b0;
                        m_left[i]  <= wid(i);
                        m_pend[i]  <= calc(wid(i), ina[i], inb[i], icin[i]);
                    end
                end else if (m_left[i] > 0) begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_valid[i] <= 1'b1;
                        m_res[i]   <= m_pend[i];
                    end
                end else if (orr[i]) begin
                    m_valid[i] <= 1'b0;
                    m_ready[i] <= 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("in_ready[%0d]", i), 66'(iready[i]), 66'(m_ready[i]));
                chk($sformatf("out_valid[%0d]", i), 66'(ovalid[i]), 66'(m_valid[i]));
                chk($sformatf("result[%0d]", i), {osum[i], ocout[i], oovf[i]}, m_res[i]);
            end
        end
    end

    task automatic run_op(input int i, input logic [63:0] x, input logic [63:0] y,
                          input logic c, input int stall, input bit lit,
                          input logic [63:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        iv[i] = 1'b1; ina[i] = x; inb[i] = y; icin[i] = c;
        @(negedge clk);
        iv[i] = 1'b0; ina[i] = 64'($urandom); inb[i] = 64'($urandom);
        n = 0;
        while (!ovalid[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency[%0d]", i), 66'(n), 66'(wid(i)));
        if (lit) chk("literal_result", {osum[i], ocout[i], oovf[i]}, {es, ec, eo});
        repeat (stall) begin
            iv[i] = 1'($urandom_range(0, 1));
            ina[i] = 64'($urandom); inb[i] = 64'($urandom); icin[i] = 1'($urandom);
            @(negedge clk);
            chk("stall_valid", 66'(ovalid[i]), 66'd1);
            chk("stall_ready", 66'(iready[i]), 66'd0);
            if (lit) chk("stall_hold", {osum[i], ocout[i], oovf[i]}, {es, ec, eo});
        end
        iv[i] = 1'b1;
        orr[i] = 1'b1;
        @(negedge clk);
        iv[i] = 1'b0;
        orr[i] = 1'b0;
        chk("release_ready", 66'(iready[i]), 66'd1);
        chk("release_valid", 66'(ovalid[i]), 66'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; orr[i] = 1'b0; ina[i] = '0; inb[i] = '0; icin[i] = 1'b0;
        end
        chk("model_5A33", calc(8, 64'h5A, 64'h33, 1'b0), {64'h8D, 1'b0, 1'b1});
        chk("model_8080", calc(8, 64'h80, 64'h80, 1'b0), {64'h00, 1'b1, 1'b1});
        chk("model_w2",   calc(2, 64'h3,  64'h1,  1'b1), {64'h1,  1'b1, 1'b0});

        repeat (2) @(negedge clk);
        chk("reset_ready", 66'(iready[0]), 66'd1);
        chk("reset_valid", 66'(ovalid[0]), 66'd0);
        chk("reset_result", {osum[0], ocout[0], oovf[0]}, 66'd0);
        rst_n = 1'b1;

        run_op(0, 64'h5A, 64'h33, 1'b0, 0, 1, 64'h8D, 1'b0, 1'b1);
        run_op(0, 64'hFF, 64'h01, 1'b0, 0, 1, 64'h00, 1'b1, 1'b0);
        run_op(0, 64'h00, 64'h00, 1'b1, 0, 1, 64'h01, 1'b0, 1'b0);
        run_op(0, 64'h80, 64'h80, 1'b0, 0, 1, 64'h00, 1'b1, 1'b1);
        run_op(0, 64'h7F, 64'h00, 1'b1, 5, 1, 64'h80, 1'b0, 1'b1);

        // Abort an operation three cycles into RUN.
        @(negedge clk);
        iv[0] = 1'b1; ina[0] = 64'hFF; inb[0] = 64'hFF; icin[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 66'(iready[0]), 66'd1);
        chk("abort_valid", 66'(ovalid[0]), 66'd0);
        chk("abort_result", {osum[0], ocout[0], oovf[0]}, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 64'h01, 64'h02, 1'b0, 0, 1, 64'h03, 1'b0, 1'b0);

        for (int k = 0; k < 30; k++)
            run_op(0, 64'($urandom), 64'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++)
            run_op(1, 64'($urandom), 64'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 0, '0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
